// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode CSR state owner and trap sequencer.
// Holds every M-mode CSR field, loads the CSR block's *_next values on an
// accepted software write, and sequences exceptions, interrupts and mret
// into a fetch redirect over a valid/ack handshake. It also runs the
// mcycle/minstret counters.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   sw_we, *_next                 committed CSR write and its field values
//   mie..mcause, mcycle/minstret  registered CSR state (fed back to CSR block)
//   mtip, msip, meip              level-sensitive pending interrupt lines
//   retire, int_ok                retire strobe, interruptible boundary
//   exc_req/exc_cause/exc_pc/exc_val  synchronous exception from execute
//   int_pc                        PC of next unexecuted instruction
//   mret_req                      mret commits this cycle
//   redirect_valid/pc/ack         fetch redirect handshake
//   busy                          sequencer not in RUN; pipeline holds commits
module trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_we,
  input  logic        mie_next,
  input  logic        mpie_next,
  input  logic        mtie_next,
  input  logic        msie_next,
  input  logic        meie_next,
  input  logic        mcycle_inhibit_next,
  input  logic        minstret_inhibit_next,
  input  logic [29:0] mtvec_base_next,
  input  logic [31:0] mscratch_next,
  input  logic [31:0] mepc_next,
  input  logic [31:0] mtval_next,
  input  logic [31:0] mcause_next,
  input  logic [63:0] mcycle_next,
  input  logic [63:0] minstret_next,
  output logic        mie,
  output logic        mpie,
  output logic        mtie,
  output logic        msie,
  output logic        meie,
  output logic        mcycle_inhibit,
  output logic        minstret_inhibit,
  output logic [29:0] mtvec_base,
  output logic [31:0] mscratch,
  output logic [31:0] mepc,
  output logic [31:0] mtval,
  output logic [31:0] mcause,
  output logic [63:0] mcycle,
  output logic [63:0] minstret,
  input  logic        mtip,
  input  logic        msip,
  input  logic        meip,
  input  logic        retire,
  input  logic        int_ok,
  input  logic        exc_req,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_val,
  input  logic [31:0] int_pc,
  input  logic        mret_req,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        busy
);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t      state, state_n;
  logic        take_exc, take_int, take_mret, take_sw;
  logic        int_any;
  logic [3:0]  int_code;

  logic        mie_d, mpie_d, mtie_d, msie_d, meie_d, cinh_d, iinh_d;
  logic [29:0] mtvec_base_d;
  logic [31:0] mscratch_d, mepc_d, mtval_d, mcause_d, redirect_pc_d;
  logic [63:0] mcycle_d, minstret_d;

  // PC low bits are always cleared in mepc, so they are never consumed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{exc_pc[1:0], int_pc[1:0]};

  // Interrupt arbitration: MEI > MSI > MTI.
  always_comb begin
    int_code = 4'd0;
    if (meip & meie)      int_code = 4'd11;
    else if (msip & msie) int_code = 4'd3;
    else if (mtip & mtie) int_code = 4'd7;
    int_any = int_ok & mie & ((meip & meie) | (msip & msie) | (mtip & mtie));
  end

  // One event per cycle in RUN; lower-priority same-cycle events are dropped.
  always_comb begin
    take_exc  = (state == RUN) & exc_req;
    take_int  = (state == RUN) & ~exc_req & int_any;
    take_mret = (state == RUN) & ~exc_req & ~int_any & mret_req;
    take_sw   = (state == RUN) & ~exc_req & ~int_any & ~mret_req & sw_we;
  end

  always_comb begin
    state_n       = state;
    mie_d         = mie;
    mpie_d        = mpie;
    mtie_d        = mtie;
    msie_d        = msie;
    meie_d        = meie;
    cinh_d        = mcycle_inhibit;
    iinh_d        = minstret_inhibit;
    mtvec_base_d  = mtvec_base;
    mscratch_d    = mscratch;
    mepc_d        = mepc;
    mtval_d       = mtval;
    mcause_d      = mcause;
    redirect_pc_d = redirect_pc;
    // Counters use the pre-write inhibit values; a software write overrides.
    mcycle_d      = mcycle_inhibit ? mcycle : mcycle + 64'd1;
    minstret_d    = (retire & ~minstret_inhibit) ? minstret + 64'd1 : minstret;

    case (state)
      RUN: begin
        if (take_exc) begin
          mepc_d        = {exc_pc[31:2], 2'b00};
          mcause_d      = {28'b0, exc_cause};
          mtval_d       = exc_val;
          mpie_d        = mie;
          mie_d         = 1'b0;
          redirect_pc_d = {mtvec_base, 2'b00};
          state_n       = REDIRECT;
        end else if (take_int) begin
          mepc_d        = {int_pc[31:2], 2'b00};
          mcause_d      = {1'b1, 27'b0, int_code};
          mtval_d       = '0;
          mpie_d        = mie;
          mie_d         = 1'b0;
          redirect_pc_d = {mtvec_base, 2'b00};
          state_n       = REDIRECT;
        end else if (take_mret) begin
          mie_d         = mpie;
          mpie_d        = 1'b1;
          redirect_pc_d = mepc;
          state_n       = REDIRECT;
        end else if (take_sw) begin
          mie_d         = mie_next;
          mpie_d        = mpie_next;
          mtie_d        = mtie_next;
          msie_d        = msie_next;
          meie_d        = meie_next;
          cinh_d        = mcycle_inhibit_next;
          iinh_d        = minstret_inhibit_next;
          mtvec_base_d  = mtvec_base_next;
          mscratch_d    = mscratch_next;
          mepc_d        = mepc_next;
          mtval_d       = mtval_next;
          mcause_d      = mcause_next;
          mcycle_d      = mcycle_next;
          minstret_d    = minstret_next;
        end
      end
      REDIRECT: begin
        if (redirect_ack) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie              <= 1'b0;
      mpie             <= 1'b0;
      mtie             <= 1'b0;
      msie             <= 1'b0;
      meie             <= 1'b0;
      mcycle_inhibit   <= 1'b0;
      minstret_inhibit <= 1'b0;
      mtvec_base       <= RESET_MTVEC[31:2];
      mscratch         <= '0;
      mepc             <= '0;
      mtval            <= '0;
      mcause           <= '0;
      mcycle           <= '0;
      minstret         <= '0;
      redirect_pc      <= '0;
    end else begin
      mie              <= mie_d;
      mpie             <= mpie_d;
      mtie             <= mtie_d;
      msie             <= msie_d;
      meie             <= meie_d;
      mcycle_inhibit   <= cinh_d;
      minstret_inhibit <= iinh_d;
      mtvec_base       <= mtvec_base_d;
      mscratch         <= mscratch_d;
      mepc             <= mepc_d;
      mtval            <= mtval_d;
      mcause           <= mcause_d;
      mcycle           <= mcycle_d;
      minstret         <= minstret_d;
      redirect_pc      <= redirect_pc_d;
    end
  end

  assign redirect_valid = (state == REDIRECT);
  assign busy           = (state != RUN);

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequential machine-mode state owner and trap sequencer. It sits directly downstream of the combinational CSR access block.
- Registers every M-mode CSR field: it consumes the CSR block's per-field next values on a committed CSR write and feeds the registered values back to it.
- Also handles trap entry, mret, interrupt arbitration and the mcycle/minstret counters.
- Issues PC redirects to fetch over a valid/ack handshake.

Parameters:
RESET_MTVEC, 32'h0000_0000, reset value of {mtvec_base,2'b00}; bits [1:0] ignored

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
sw_we  in  1  committed CSR-instruction write this cycle; the CSR block's *_next values are valid
mie_next, mpie_next, mtie_next, msie_next, meie_next, mcycle_inhibit_next, minstret_inhibit_next  in  1 each  software next values
mtvec_base_next  in  30  software next value
mscratch_next, mepc_next, mtval_next  in  32 each  software next values
mcause_next  in  32  software next value
mcycle_next, minstret_next  in  64 each  software next values
mie, mpie, mtie, msie, meie, mcycle_inhibit, minstret_inhibit  out  1 each  registered state
mtvec_base  out  30  registered state
mscratch, mepc, mtval, mcause  out  32 each  registered state
mcycle, minstret  out  64 each  registered state
mtip, msip, meip  in  1 each  raw pending lines, level-sensitive
retire  in  1  one instruction retired this cycle
int_ok  in  1  pipeline at an interruptible instruction boundary
exc_req  in  1  synchronous exception from execute
exc_cause  in  4  exception code; MSB of mcause forced 0
exc_pc, exc_val  in  32 each  faulting PC, trap value
int_pc  in  32  PC of the next unexecuted instruction, for interrupts
mret_req  in  1  mret commits this cycle
redirect_valid  out  1  fetch redirect pending
redirect_pc  out  32  redirect target
redirect_ack  in  1  fetch accepted redirect
busy  out  1  state != RUN; pipeline must hold commits

Behaviour:
- Reset (async, rst_n low):
  - mie=mpie=mtie=msie=meie=0; inhibits=0.
  - mtvec_base=RESET_MTVEC[31:2].
  - mscratch=mepc=mtval=mcause=0; mcycle=minstret=0.
  - redirect_valid=0, redirect_pc=0, state=RUN.
- FSM states: RUN, REDIRECT.
- In RUN, one event per cycle is accepted, in priority order exc_req > interrupt > mret_req > sw_we.
  - interrupt = int_ok & mie & ((meip&meie)|(msip&msie)|(mtip&mtie)).
  - Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- Exception accepted:
  - mepc={exc_pc[31:2],2'b00}; mcause={28'b0,exc_cause}; mtval=exc_val.
  - mpie=mie; mie=0.
  - Registered redirect_pc={mtvec_base,2'b00}; go to REDIRECT.
- Interrupt accepted:
  - mepc={int_pc[31:2],2'b00}; mcause={1'b1,27'b0,code}; mtval=0.
  - mpie=mie; mie=0; redirect to mtvec; go to REDIRECT.
- mret accepted: mie=mpie; mpie=1; redirect_pc=mepc; go to REDIRECT.
- sw_we accepted: every state field loads its *_next value, except that the counters follow the counter rule below. No redirect.
- A lower-priority event arriving in the same cycle as a higher one is dropped; the pipeline must squash it.
- REDIRECT:
  - redirect_valid=1 and busy=1 are registered outputs, asserted the cycle after acceptance.
  - Exit to RUN on the cycle redirect_ack=1; redirect_valid deasserts on the next edge.
  - exc_req, mret_req, sw_we and interrupts are ignored while in REDIRECT.
  - redirect_pc is stable while redirect_valid=1.
- Counters, evaluated every cycle in any state:
  - mcycle += 1 unless mcycle_inhibit.
  - minstret += 1 if retire & !minstret_inhibit.
  - Both wrap modulo 2^64.
  - An accepted sw_we loads the software value for that counter and suppresses its increment that cycle.
  - The inhibit value used is the pre-write registered value.
- The trap uses the registered mtvec_base, never a same-cycle sw value.
- Latency: event accepted at edge N; redirect_valid=1 after edge N; earliest RUN after the edge where ack is sampled.

Test Plan:
- Reset release -> all outputs at reset values; after 5 cycles mcycle=5, minstret=0, redirect_valid=0.
- mtvec_base=30'h100 (mtvec 0x400), mie=1; exc_req with cause 2, exc_pc=0x1002, exc_val=0xDEAD -> mepc=0x1000, mcause=2, mtval=0xDEAD, mie=0, mpie=1, redirect 0x400; ack after 3 cycles -> busy falls, state RUN.
- mie=1, meie=mtie=1, meip=mtip=1, int_ok=1, int_pc=0x2000 -> mcause=0x8000000B, mepc=0x2000, mtval=0; repeat with meip=0 -> mcause=0x80000007.
- exc_req, interrupt, mret_req and sw_we (mscratch_next=5) all in one cycle -> exception taken; mscratch unchanged; mpie unchanged by mret.
- mret with mepc=0x3000, mpie=1, mie=0 -> mie=1, mpie=1, redirect_pc=0x3000; sw_we asserted during REDIRECT -> ignored.
- mcycle=64'hFFFF_FFFF_FFFF_FFFF -> wraps to 0. sw_we with mcycle_next=100 -> mcycle=100 next cycle, then 101. minstret_inhibit=1 with retire=1 -> minstret holds.
